// File: rtl/pipe_controller.sv
// ID-stage main decode with ID/EX control register, load-use and multi-cycle
// divide stall generation, and branch-flush squash.
module pipe_controller #(
  parameter int unsigned MULDIV_EN  = 1,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic       stall,
  output logic       md_busy,
  output logic       ex_valid,
  output logic       ex_ALUSrc,
  output logic       ex_MemtoReg,
  output logic       ex_RegWrite,
  output logic       ex_MemRead,
  output logic       ex_MemWrite,
  output logic       ex_Branch,
  output logic       ex_JalrSel,
  output logic       ex_MulDiv,
  output logic       ex_Illegal,
  output logic [2:0] ex_ALUOp,
  output logic [4:0] ex_rd
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(DIV_CYCLES - 1);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       memto_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jalr_sel;
    logic       muldiv;
    logic       illegal;
    logic [2:0] alu_op;
    logic [4:0] rd;
  } ctrl_t;

  ctrl_t           dec;
  ctrl_t           ex_d, ex_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            use_rs1, use_rs2, is_div, load_use;
  logic            unused_funct3;

  // Only Funct3[2] distinguishes divide from multiply here.
  assign unused_funct3 = ^Funct3[1:0];

  // Decode ID fields into EX controls; bubble when ID holds no instruction.
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (Opcode)
      OpR: begin
        use_rs2 = 1'b1;
        if (Funct7 == 7'b0000001) begin
          if (MULDIV_EN != 0) begin
            dec.muldiv    = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = 3'b110;
            dec.rd        = id_rd;
          end else begin
            dec.illegal = 1'b1;
          end
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_op    = 3'b010;
          dec.rd        = id_rd;
        end
      end
      OpI: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b010; dec.rd = id_rd;
      end
      OpLw: begin
        dec.alu_src  = 1'b1; dec.memto_reg = 1'b1; dec.reg_write = 1'b1;
        dec.mem_read = 1'b1; dec.alu_op    = 3'b000; dec.rd       = id_rd;
      end
      OpSw: begin
        use_rs2 = 1'b1;
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = 3'b000; dec.rd = id_rd;
      end
      OpBr: begin
        use_rs2 = 1'b1;
        dec.branch = 1'b1; dec.alu_op = 3'b001; dec.rd = id_rd;
      end
      OpJal: begin
        use_rs1 = 1'b0;
        dec.reg_write = 1'b1; dec.branch = 1'b1; dec.alu_op = 3'b011; dec.rd = id_rd;
      end
      OpJalr: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.branch = 1'b1;
        dec.jalr_sel = 1'b1; dec.alu_op = 3'b011; dec.rd = id_rd;
      end
      OpLui: begin
        use_rs1 = 1'b0;
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b100; dec.rd = id_rd;
      end
      OpAuipc: begin
        use_rs1 = 1'b0;
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b101; dec.rd = id_rd;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.valid = 1'b1;
    if (!id_valid) dec = '0;
    is_div = dec.muldiv & Funct3[2];
  end

  // Hazard detection against the load currently in EX; x0 never hazards.
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
               ((use_rs1 & (ex_q.rd == id_rs1)) | (use_rs2 & (ex_q.rd == id_rs2)));
    md_busy  = (cnt_q != '0);
    stall    = md_busy | load_use;
  end

  // ID/EX next state: flush beats divide hold, hold beats load-use bubble.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
    if (flush) begin
      ex_d  = '0;
      cnt_d = '0;
    end else if (md_busy) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d  = dec;
      cnt_d = is_div ? CntLoad : '0;
    end
  end

  // ID/EX control register and divide occupancy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_MemtoReg = ex_q.memto_reg;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_Branch   = ex_q.branch;
  assign ex_JalrSel  = ex_q.jalr_sel;
  assign ex_MulDiv   = ex_q.muldiv;
  assign ex_Illegal  = ex_q.illegal;
  assign ex_ALUOp    = ex_q.alu_op;
  assign ex_rd       = ex_q.rd;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench: u_dut has RV32M and an 8-cycle divide, u_alt has RV32M
// disabled and a 1-cycle divide; both see the same ID stream.
module tb_pipe_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       flush;

  logic       stall, md_busy;
  logic       ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite;
  logic       ex_Branch, ex_JalrSel, ex_MulDiv, ex_Illegal;
  logic [2:0] ex_ALUOp;
  logic [4:0] ex_rd;

  logic       a_stall, a_md_busy;
  logic       a_valid, a_ALUSrc, a_MemtoReg, a_RegWrite, a_MemRead, a_MemWrite;
  logic       a_Branch, a_JalrSel, a_MulDiv, a_Illegal;
  logic [2:0] a_ALUOp;
  logic [4:0] a_rd;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cnt, div_cnt, alt_stall_cnt, add_edge;

  // {valid, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JalrSel, MulDiv, Illegal}
  logic [9:0] flags, a_flags;
  assign flags   = {ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                    ex_Branch, ex_JalrSel, ex_MulDiv, ex_Illegal};
  assign a_flags = {a_valid, a_ALUSrc, a_MemtoReg, a_RegWrite, a_MemRead, a_MemWrite,
                    a_Branch, a_JalrSel, a_MulDiv, a_Illegal};

  localparam logic [9:0] FlLw   = 10'b1111100000;
  localparam logic [9:0] FlAlu  = 10'b1001000000;
  localparam logic [9:0] FlMd   = 10'b1001000010;
  localparam logic [9:0] FlIll  = 10'b1000000001;
  localparam logic [9:0] FlLui  = 10'b1101000000;
  localparam logic [9:0] FlJalr = 10'b1101001100;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] F7Md   = 7'b0000001;

  pipe_controller #(.MULDIV_EN(1), .DIV_CYCLES(8)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .Opcode(Opcode), .Funct3(Funct3),
    .Funct7(Funct7), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .stall(stall), .md_busy(md_busy), .ex_valid(ex_valid), .ex_ALUSrc(ex_ALUSrc),
    .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_JalrSel(ex_JalrSel),
    .ex_MulDiv(ex_MulDiv), .ex_Illegal(ex_Illegal), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd)
  );

  pipe_controller #(.MULDIV_EN(0), .DIV_CYCLES(1)) u_alt (
    .clk(clk), .reset(reset), .id_valid(id_valid), .Opcode(Opcode), .Funct3(Funct3),
    .Funct7(Funct7), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .stall(a_stall), .md_busy(a_md_busy), .ex_valid(a_valid), .ex_ALUSrc(a_ALUSrc),
    .ex_MemtoReg(a_MemtoReg), .ex_RegWrite(a_RegWrite), .ex_MemRead(a_MemRead),
    .ex_MemWrite(a_MemWrite), .ex_Branch(a_Branch), .ex_JalrSel(a_JalrSel),
    .ex_MulDiv(a_MulDiv), .ex_Illegal(a_Illegal), .ex_ALUOp(a_ALUOp), .ex_rd(a_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid = 1'b1;
    Opcode   = op;
    Funct3   = f3;
    Funct7   = f7;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_rd    = rd;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    // Reset held with LW x5 in ID
    instr(OpLw, 3'b010, 7'd0, 5'd1, 5'd0, 5'd5);
    tick();
    tick();
    chk("rst_flags", {22'd0, flags}, 32'd0);
    chk("rst_busy_stall", {30'd0, md_busy, stall}, 32'd0);
    chk("rst_alt_flags", {22'd0, a_flags}, 32'd0);
    reset = 1'b1;
    tick();
    chk("lw_flags", {22'd0, flags}, {22'd0, FlLw});
    chk("lw_aluop_rd", {24'd0, ex_ALUOp, ex_rd}, {24'd0, 3'b000, 5'd5});

    // ADD x6,x5,x7 behind LW x5: one bubble
    instr(OpR, 3'b000, 7'd0, 5'd5, 5'd7, 5'd6);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {22'd0, flags}, 32'd0);
    chk("lu_stall_clear", {31'd0, stall}, 32'd0);
    tick();
    chk("add_flags", {22'd0, flags}, {22'd0, FlAlu});
    chk("add_aluop_rd", {24'd0, ex_ALUOp, ex_rd}, {24'd0, 3'b010, 5'd6});

    // LW x0 then ADD x6,x0,x7: no hazard through x0
    instr(OpLw, 3'b010, 7'd0, 5'd1, 5'd0, 5'd0);
    tick();
    instr(OpR, 3'b000, 7'd0, 5'd0, 5'd7, 5'd6);
    chk("x0_no_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("x0_add_flags", {22'd0, flags}, {22'd0, FlAlu});

    // MUL: single cycle on u_dut, illegal on u_alt
    instr(OpR, 3'b000, F7Md, 5'd1, 5'd2, 5'd3);
    tick();
    chk("mul_flags", {22'd0, flags}, {22'd0, FlMd});
    chk("mul_aluop", {29'd0, ex_ALUOp}, 32'd6);
    chk("mul_no_busy", {30'd0, md_busy, stall}, 32'd0);
    chk("mul_alt_illegal", {22'd0, a_flags}, {22'd0, FlIll});

    // DIV x8 then ADD x9: 8 cycles in EX, 7 stall cycles, ADD on 9th edge
    instr(OpR, 3'b100, F7Md, 5'd1, 5'd2, 5'd8);
    tick();
    chk("div_flags", {22'd0, flags}, {22'd0, FlMd});
    chk("div_alt_illegal", {22'd0, a_flags}, {22'd0, FlIll});
    instr(OpR, 3'b000, 7'd0, 5'd1, 5'd2, 5'd9);
    stall_cnt = 0; div_cnt = 0; alt_stall_cnt = 0; add_edge = -1;
    for (int i = 0; i < 12; i++) begin
      if (stall) stall_cnt++;
      if (a_stall) alt_stall_cnt++;
      if (ex_MulDiv) div_cnt++;
      if (ex_rd == 5'd9 && add_edge < 0) add_edge = i;
      tick();
    end
    chk("div_stall_cycles", stall_cnt, 32'd7);
    chk("div_ex_cycles", div_cnt, 32'd8);
    chk("div_add_edge", add_edge, 32'd8);
    chk("div1_no_stall", alt_stall_cnt, 32'd0);

    // Flush during load-use stall
    instr(OpLw, 3'b010, 7'd0, 5'd1, 5'd0, 5'd5);
    tick();
    instr(OpR, 3'b000, 7'd0, 5'd2, 5'd5, 5'd6);
    flush = 1'b1;
    #1;
    chk("flush_lu_stall", {31'd0, stall}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_lu_bubble", {22'd0, flags}, 32'd0);
    chk("flush_lu_after", {30'd0, md_busy, stall}, 32'd0);

    // Flush during divide busy
    instr(OpR, 3'b101, F7Md, 5'd1, 5'd2, 5'd8);
    tick();
    instr(OpR, 3'b000, 7'd0, 5'd1, 5'd2, 5'd9);
    tick();
    chk("fdiv_busy", {31'd0, md_busy}, 32'd1);
    flush = 1'b1;
    #1;
    chk("fdiv_stall", {31'd0, stall}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("fdiv_bubble", {22'd0, flags}, 32'd0);
    chk("fdiv_after", {30'd0, md_busy, stall}, 32'd0);

    // Unlisted opcode
    instr(7'b1111111, 3'b000, 7'd0, 5'd1, 5'd2, 5'd4);
    tick();
    chk("illegal_flags", {22'd0, flags}, {22'd0, FlIll});
    chk("illegal_aluop", {29'd0, ex_ALUOp}, 32'd0);

    // LUI whose instr[19:15] matches a load rd: no hazard
    instr(OpLw, 3'b010, 7'd0, 5'd1, 5'd0, 5'd10);
    tick();
    instr(OpLui, 3'b000, 7'd0, 5'd10, 5'd10, 5'd11);
    chk("lui_no_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("lui_flags", {22'd0, flags}, {22'd0, FlLui});
    chk("lui_aluop_rd", {24'd0, ex_ALUOp, ex_rd}, {24'd0, 3'b100, 5'd11});

    // JALR
    instr(OpJalr, 3'b000, 7'd0, 5'd1, 5'd0, 5'd1);
    tick();
    chk("jalr_flags", {22'd0, flags}, {22'd0, FlJalr});
    chk("jalr_aluop", {29'd0, ex_ALUOp}, 32'd3);

    // id_valid low: bubble
    id_valid = 1'b0;
    tick();
    chk("invalid_bubble", {22'd0, flags}, 32'd0);

    // Reset in the middle of a divide
    instr(OpR, 3'b110, F7Md, 5'd1, 5'd2, 5'd8);
    tick();
    tick();
    chk("rdiv_busy", {31'd0, md_busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rdiv_cleared", {20'd0, flags, md_busy, stall}, 32'd0);
    tick();
    reset = 1'b1;
    instr(OpR, 3'b000, 7'd0, 5'd1, 5'd2, 5'd9);
    chk("rdiv_no_residual", {30'd0, md_busy, stall}, 32'd0);
    tick();
    chk("rdiv_add", {22'd0, flags}, {22'd0, FlAlu});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
